ahb2apb: RTL and testbench
==========================

Name: ahb2apb

Overview:
AHB-lite slave to APB4 master bridge, placed directly downstream of the AXI-lite to AHB bridge: it consumes that bridge's AHB transfers and drives the peripheral APB bus. One AHB transfer maps to exactly one APB access. The bridge inserts AHB wait states until the APB access completes. APB slave errors, timeouts and illegal size or alignment combinations are returned as a two-cycle AHB ERROR response.

Parameters:
AWIDTH, 16, address width for haddr and paddr.
DWIDTH, 32, data width; only 32 is supported, elaboration fails otherwise.
TIMEOUT, 16, maximum number of ACCESS cycles without pready before abort; 0 disables the timeout.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
haddr  in  AWIDTH  AHB address
hwdata  in  DWIDTH  AHB write data, valid during the data phase
hsel  in  1  slave select
hwrite  in  1  1 = write
htrans  in  2  transfer type; only bit 1 (NONSEQ/SEQ) starts a transfer
hsize  in  3  transfer size: 0 = byte, 1 = half, 2 = word
hready  out  1  transfer done / bridge ready
hrdata  out  DWIDTH  read data
hresp  out  2  00 = OKAY, 01 = ERROR
paddr  out  AWIDTH  APB address
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  DWIDTH  APB write data
pstrb  out  DWIDTH/8  APB byte strobes; all zero on reads
prdata  in  DWIDTH  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error

Behaviour:
- Reset is asynchronous on rst high. Reset values: state=IDLE, hready=1, hresp=00, hrdata=0, psel=0, penable=0, paddr=0, pwrite=0, pstrb=0, timeout counter=0.
- Accept condition: hsel & htrans[1] & hready (hready is the bridge's own output). Acceptance is possible only in IDLE and ERR2.
- hsel=0, or htrans IDLE/BUSY: ignored; hready stays 1, hresp=OKAY.
- On accept, latch haddr→paddr and hwrite→pwrite, and compute pstrb:
  - byte: 1 << haddr[1:0]
  - half: 0011 << haddr[1:0]
  - word: 1111
  - reads: pstrb=0
- Illegal transfer: hsize>2, half with haddr[0]=1, or word with haddr[1:0]≠0. No APB access; next state ERR1.
- Legal transfer: next state SETUP, hready<=0, psel<=1.
- States:
  - IDLE: hready=1, hresp=OKAY.
  - SETUP: psel=1, penable=0; next cycle goes to ACCESS with penable<=1, counter cleared.
  - ACCESS, pready=1 & pslverr=0: psel<=0, penable<=0, hready<=1, hrdata<=prdata on reads; next IDLE.
  - ACCESS, pready=1 & pslverr=1: psel<=0, penable<=0; next ERR1.
  - ACCESS, pready=0: counter increments. If TIMEOUT≠0 and counter reaches TIMEOUT-1, drop psel/penable and go to ERR1.
  - ERR1: hresp=ERROR, hready=0; next ERR2.
  - ERR2: hresp=ERROR, hready=1; next IDLE, or SETUP/ERR1 if a new transfer is accepted in this cycle.
- pwdata is driven combinationally from hwdata. This is legal because hready stays low for the whole data phase, which keeps hwdata stable through SETUP and ACCESS.
- paddr, pwrite and pstrb hold their values after an access until the next accept.
- hrdata holds its last read value; it is not updated on writes or errors.
- Latency with a zero-wait APB slave: accept edge, then SETUP, ACCESS, then hready=1 in the 3rd cycle after accept. Each APB wait state adds one cycle.
- Back-to-back: a transfer presented in the cycle hready returns to 1 is accepted with no bubble.
- Reset during an APB access: psel and penable drop immediately; no response is generated.

Decomposition:
- Shared package ahb_apb_pkg contains:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ, HSIZE_BYTE/HALF/WORD and HRESP_OKAY/ERROR constants;
  - ahb2apb_state_t enum: IDLE, SETUP, ACCESS, ERR1, ERR2;
  - function calc_pstrb(hsize, addr_lsb, write), returning 4 bits;
  - function is_misaligned(hsize, addr_lsb).
- No sub-module; the timeout counter is inline with width $clog2(TIMEOUT+1).

Test Plan:
- Word write 0x0010 ← 0xDEADBEEF, pready=1 immediately.
  - Expect psel 2 cycles, penable 1 cycle, pwrite=1, pstrb=1111, pwdata=0xDEADBEEF.
  - Expect hready low 2 cycles, hresp=OKAY.
- Byte write at 0x0013, then half read at 0x0002 with pready delayed 3 cycles, prdata=0x12345678.
  - Expect pstrb=1000 on the write.
  - Expect hrdata=0x12345678 on the read, with hready low 5 cycles.
- Word read with pslverr=1 at pready.
  - Expect hresp=01 with hready=0, then hresp=01 with hready=1, then OKAY.
- Word access at 0x0002, and hsize=3.
  - Expect no psel assertion and the two-cycle ERROR response for each.
- TIMEOUT=4, pready held at 0.
  - Expect psel/penable to drop after 4 ACCESS cycles, then ERROR response.
  - Then assert rst mid-SETUP and expect psel=0, hready=1 asynchronously.

Source files
------------

// File: rtl/ahb_apb_pkg.sv
// Shared AHB/APB encodings, bridge state type and strobe/alignment helpers
// used by the AHB-lite to APB4 bridge.
package ahb_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        ERR1,
        ERR2
    } ahb2apb_state_t;

    // Byte lanes touched by a write; reads never assert strobes.
    function automatic logic [3:0] calc_pstrb(input logic [2:0] hsize,
                                              input logic [1:0] addr_lsb,
                                              input logic       write);
        logic [3:0] strb;
        strb = 4'b0000;
        if (write) begin
            case (hsize)
                HSIZE_BYTE: strb = 4'b0001 << addr_lsb;
                HSIZE_HALF: strb = 4'b0011 << addr_lsb;
                HSIZE_WORD: strb = 4'b1111;
                default:    strb = 4'b0000;
            endcase
        end
        return strb;
    endfunction

    // Oversized transfers count as misaligned so they share the error path.
    function automatic logic is_misaligned(input logic [2:0] hsize,
                                           input logic [1:0] addr_lsb);
        logic bad;
        case (hsize)
            HSIZE_BYTE: bad = 1'b0;
            HSIZE_HALF: bad = addr_lsb[0];
            HSIZE_WORD: bad = |addr_lsb;
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ahb2apb.sv
// AHB-lite slave to APB4 master bridge: one AHB transfer becomes one APB
// access, with wait states until completion and a two-cycle ERROR response.
module ahb2apb
    import ahb_apb_pkg::*;
#(
    parameter int AWIDTH  = 16,
    parameter int DWIDTH  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AWIDTH-1:0]     haddr,
    input  logic [DWIDTH-1:0]     hwdata,
    input  logic                  hsel,
    input  logic                  hwrite,
    input  logic [1:0]            htrans,
    input  logic [2:0]            hsize,
    output logic                  hready,
    output logic [DWIDTH-1:0]     hrdata,
    output logic [1:0]            hresp,
    output logic [AWIDTH-1:0]     paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DWIDTH-1:0]     pwdata,
    output logic [DWIDTH/8-1:0]   pstrb,
    input  logic [DWIDTH-1:0]     prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    generate
        if (DWIDTH != 32) begin : g_dwidth_check
            $error("ahb2apb supports DWIDTH = 32 only");
        end
    endgenerate

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    ahb2apb_state_t state, state_next;
    logic [CW-1:0]  to_cnt;
    logic           xfer_req;
    logic           accept;
    logic           illegal;
    logic           to_hit;

    // NOTE: every always_comb output gets a default before the case so no
    // path through it can infer a latch.
    always_comb begin
        xfer_req = 1'b0;
        case (htrans)
            HTRANS_IDLE, HTRANS_BUSY:  xfer_req = 1'b0;
            HTRANS_NONSEQ, HTRANS_SEQ: xfer_req = 1'b1;
            default:                   xfer_req = 1'b0;
        endcase
    end

    assign accept  = hsel & xfer_req & hready;
    assign illegal = is_misaligned(hsize, haddr[1:0]);
    assign to_hit  = (TIMEOUT != 0) && (to_cnt == TO_LAST);

    // hready is low for the whole data phase, so hwdata is stable through
    // SETUP and ACCESS and can feed the APB bus without a register.
    assign pwdata = hwdata;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, ERR2: begin
                if (accept) begin
                    state_next = illegal ? ERR1 : SETUP;
                end else begin
                    state_next = IDLE;
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    state_next = pslverr ? ERR1 : IDLE;
                end else if (to_hit) begin
                    state_next = ERR1;
                end
            end
            ERR1: begin
                state_next = ERR2;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bus-facing controls are flops loaded from the next state, so neither
    // the AHB nor the APB side ever sees a decode glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hready  <= 1'b1;
            hresp   <= HRESP_OKAY;
            psel    <= 1'b0;
            penable <= 1'b0;
        end else begin
            hready  <= (state_next == IDLE) || (state_next == ERR2);
            hresp   <= (state_next inside {ERR1, ERR2}) ? HRESP_ERROR : HRESP_OKAY;
            psel    <= (state_next == SETUP) || (state_next == ACCESS);
            penable <= (state_next == ACCESS);
        end
    end

    // Address, direction and strobes hold after an access until the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            paddr  <= '0;
            pwrite <= 1'b0;
            pstrb  <= '0;
        end else if (accept) begin
            paddr  <= haddr;
            pwrite <= hwrite;
            pstrb  <= calc_pstrb(hsize, haddr[1:0], hwrite);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hrdata <= '0;
        end else if ((state == ACCESS) && pready && !pslverr && !pwrite) begin
            hrdata <= prdata;
        end
    end

    // Counts ACCESS cycles spent waiting for pready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state == SETUP) begin
            to_cnt <= '0;
        end else if ((state == ACCESS) && !pready) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ahb2apb.sv
// Self-checking bench for ahb2apb: directed vector table, randomized
// transfers against a transfer-level reference model, and hand sequences.
module tb_ahb2apb;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] haddr;
    logic [31:0] hwdata;
    logic        hsel;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hready;
    logic [31:0] hrdata;
    logic [1:0]  hresp;
    logic [15:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    ahb2apb #(.AWIDTH(16), .DWIDTH(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .haddr(haddr), .hwdata(hwdata), .hsel(hsel),
        .hwrite(hwrite), .htrans(htrans), .hsize(hsize), .hready(hready),
        .hrdata(hrdata), .hresp(hresp), .paddr(paddr), .psel(psel),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int          slave_waits;
    logic        slave_err;
    logic [31:0] slave_rdata;

    typedef struct {
        logic [15:0] addr;
        logic [2:0]  size;
        logic        write;
        logic [31:0] wdata;
        int          waits;
        logic        err;
        logic [31:0] rdata;
        int          exp_low;
        logic [1:0]  exp_resp;
        int          exp_psel;
        int          exp_pen;
        logic [3:0]  exp_pstrb;
        logic [31:0] exp_hrdata;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [15:0] a, logic [2:0] s, logic w, logic [31:0] wd,
                                int wt, logic e, logic [31:0] rd, int lo, logic [1:0] rs,
                                int ps, int pe, logic [3:0] st, logic [31:0] hr);
        vec_t v;
        v.addr = a; v.size = s; v.write = w; v.wdata = wd; v.waits = wt; v.err = e;
        v.rdata = rd; v.exp_low = lo; v.exp_resp = rs; v.exp_psel = ps; v.exp_pen = pe;
        v.exp_pstrb = st; v.exp_hrdata = hr;
        return v;
    endfunction

    // Byte lanes covered by the transfer, built byte by byte from its size.
    function automatic logic [3:0] ref_strobes(logic [2:0] size, logic [15:0] addr, logic write);
        logic [3:0] m;
        int nbytes;
        int base;
        m = 4'b0000;
        nbytes = 1 << size;
        base = int'(addr) % 4;
        if (write) begin
            for (int i = 0; i < nbytes; i++) begin
                if (base + i < 4) m[base + i] = 1'b1;
            end
        end
        return m;
    endfunction

    // Transfer-level model: cycle counts and response from the bridge rules.
    function automatic vec_t predict(vec_t v, logic [31:0] cur_hrdata);
        vec_t r;
        int   nbytes;
        bit   legal;
        int   acc;
        r = v;
        nbytes = 1 << v.size;
        legal = (v.size <= 3'd2) && ((int'(v.addr) % nbytes) == 0);
        r.exp_hrdata = cur_hrdata;
        r.exp_pstrb  = ref_strobes(v.size, v.addr, v.write);
        if (!legal) begin
            r.exp_low = 1; r.exp_resp = 2'b01; r.exp_psel = 0; r.exp_pen = 0;
        end else begin
            acc = v.waits + 1;
            if (acc > TIMEOUT) begin
                acc = TIMEOUT;
                r.exp_low = acc + 2; r.exp_resp = 2'b01;
            end else if (v.err) begin
                r.exp_low = acc + 2; r.exp_resp = 2'b01;
            end else begin
                r.exp_low = acc + 1; r.exp_resp = 2'b00;
                if (!v.write) r.exp_hrdata = v.rdata;
            end
            r.exp_psel = acc + 1;
            r.exp_pen  = acc;
        end
        return r;
    endfunction

    // APB slave: completes on the (waits+1)-th ACCESS cycle.
    initial begin
        int acc_cnt;
        acc_cnt = 0;
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (psel && penable) begin
                acc_cnt++;
                pready  = (acc_cnt > slave_waits);
                pslverr = pready && slave_err;
                prdata  = slave_rdata;
            end else begin
                acc_cnt = 0;
                pready  = 1'b0;
                pslverr = 1'b0;
                prdata  = 32'h0;
            end
        end
    end

    task automatic run_vec(input vec_t v, input string tag);
        int          low, err_low, psel_n, pen_n;
        logic [1:0]  fin_resp;
        logic [3:0]  cap_strb;
        logic [15:0] cap_addr;
        logic        cap_wr;
        logic [31:0] cap_wdata;
        bit          done;
        low = 0; err_low = 0; psel_n = 0; pen_n = 0; done = 0;
        fin_resp = 2'b11; cap_strb = 4'h0; cap_addr = 16'h0; cap_wr = 1'b0; cap_wdata = 32'h0;
        slave_waits = v.waits; slave_err = v.err; slave_rdata = v.rdata;
        haddr = v.addr; hsize = v.size; hwrite = v.write; hsel = 1'b1; htrans = 2'b10;
        hwdata = 32'h0;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = v.wdata;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (psel) begin
                if (psel_n == 0) begin
                    cap_strb = pstrb; cap_addr = paddr; cap_wr = pwrite; cap_wdata = pwdata;
                end
                psel_n++;
            end
            if (penable) pen_n++;
            if (hready) begin
                fin_resp = hresp;
                done = 1;
                break;
            end
            low++;
            if (hresp == 2'b01) err_low++;
            @(posedge clk); #1;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_hready_low"}, low, v.exp_low);
        check({tag, "_err_low_cycles"}, err_low, v.exp_resp);
        check({tag, "_final_resp"}, fin_resp, v.exp_resp);
        check({tag, "_psel_cycles"}, psel_n, v.exp_psel);
        check({tag, "_penable_cycles"}, pen_n, v.exp_pen);
        if (v.exp_psel > 0) begin
            check({tag, "_pstrb"}, cap_strb, v.exp_pstrb);
            check({tag, "_paddr"}, cap_addr, v.addr);
            check({tag, "_pwrite"}, cap_wr, v.write);
            if (v.write) check({tag, "_pwdata"}, cap_wdata, v.wdata);
        end
        check({tag, "_hrdata"}, hrdata, v.exp_hrdata);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_idle_hready"}, hready, 1);
        check({tag, "_idle_hresp"}, hresp, 2'b00);
        @(posedge clk); #1;
    endtask

    task automatic wait_hready(input string name);
        bit ok;
        ok = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (hready) begin
                ok = 1;
                break;
            end
        end
        check(name, ok, 1);
    endtask

    vec_t        tbl[8];
    vec_t        v;
    logic [31:0] cur_hrdata;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected completion before 200000");
        $fatal(1);
    end

    initial begin
        int s;
        rst = 1'b1; hsel = 1'b0; htrans = 2'b00; haddr = 16'h0; hwrite = 1'b0;
        hsize = 3'd0; hwdata = 32'h0;
        slave_waits = 0; slave_err = 1'b0; slave_rdata = 32'h0;

        #12;
        check("rst_hready", hready, 1);
        check("rst_hresp", hresp, 2'b00);
        check("rst_hrdata", hrdata, 32'h0);
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_paddr", paddr, 16'h0);
        check("rst_pwrite", pwrite, 0);
        check("rst_pstrb", pstrb, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        //          addr     sz  w  wdata         waits err rdata         low resp psel pen strb  hrdata
        tbl[0] = mk(16'h0010, 2, 1, 32'hDEADBEEF, 0,   0, 32'h0,          2, 2'b00, 2, 1, 4'hF, 32'h0);
        tbl[1] = mk(16'h0013, 0, 1, 32'hAB000000, 0,   0, 32'h0,          2, 2'b00, 2, 1, 4'h8, 32'h0);
        tbl[2] = mk(16'h0002, 1, 0, 32'h0,        3,   0, 32'h12345678,   5, 2'b00, 5, 4, 4'h0, 32'h12345678);
        tbl[3] = mk(16'h0020, 2, 0, 32'h0,        0,   1, 32'hFFFF0000,   3, 2'b01, 2, 1, 4'h0, 32'h12345678);
        tbl[4] = mk(16'h0002, 2, 1, 32'h55555555, 0,   0, 32'h0,          1, 2'b01, 0, 0, 4'h0, 32'h12345678);
        tbl[5] = mk(16'h0000, 3, 0, 32'h0,        0,   0, 32'h0,          1, 2'b01, 0, 0, 4'h0, 32'h12345678);
        tbl[6] = mk(16'h0030, 2, 0, 32'h0,        100, 0, 32'hCCCCCCCC,   6, 2'b01, 5, 4, 4'h0, 32'h12345678);
        tbl[7] = mk(16'h0006, 1, 1, 32'h9ABC0000, 1,   0, 32'h0,          3, 2'b00, 3, 2, 4'hC, 32'h12345678);
        for (int i = 0; i < 8; i++) begin
            run_vec(tbl[i], $sformatf("t%0d", i));
        end
        cur_hrdata = 32'h12345678;

        for (int i = 0; i < 40; i++) begin
            v.addr  = 16'($urandom);
            s       = int'($urandom_range(0, 9));
            v.size  = (s < 3) ? 3'd0 : (s < 6) ? 3'd1 : (s < 9) ? 3'd2 : 3'd3 + 3'($urandom_range(0, 4));
            v.write = 1'($urandom);
            v.wdata = $urandom;
            v.waits = ($urandom_range(0, 7) == 0) ? 6 : int'($urandom_range(0, 3));
            v.err   = ($urandom_range(0, 7) == 0);
            v.rdata = $urandom;
            v = predict(v, cur_hrdata);
            run_vec(v, $sformatf("r%0d", i));
            cur_hrdata = v.exp_hrdata;
        end

        // New transfer accepted in ERR2 goes straight to SETUP.
        slave_waits = 0; slave_err = 1'b0; slave_rdata = 32'hCAFEF00D;
        haddr = 16'h0000; hsize = 3'd3; hwrite = 1'b1; hsel = 1'b1; htrans = 2'b10;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00;
        wait_hready("b2b_err_wait");
        check("b2b_err2_resp", hresp, 2'b01);
        haddr = 16'h0040; hsize = 3'd2; hwrite = 1'b0; hsel = 1'b1; htrans = 2'b11;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00;
        @(negedge clk);
        check("b2b_err_setup_psel", psel, 1);
        check("b2b_err_setup_penable", penable, 0);
        check("b2b_err_setup_hresp", hresp, 2'b00);
        check("b2b_err_setup_paddr", paddr, 16'h0040);
        wait_hready("b2b_read_wait");
        check("b2b_read_hrdata", hrdata, 32'hCAFEF00D);
        check("b2b_read_hresp", hresp, 2'b00);
        // Another transfer in the cycle hready returns high: no bubble.
        haddr = 16'h0044; hsize = 3'd2; hwrite = 1'b1; hwdata = 32'h0; hsel = 1'b1; htrans = 2'b10;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'h01020304;
        @(negedge clk);
        check("b2b_ok_setup_psel", psel, 1);
        check("b2b_ok_pstrb", pstrb, 4'hF);
        wait_hready("b2b_write_wait");
        @(posedge clk); #1;

        // Asynchronous reset in the middle of SETUP.
        haddr = 16'h0050; hsize = 3'd2; hwrite = 1'b0; hsel = 1'b1; htrans = 2'b10;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00;
        check("rst_mid_pre_psel", psel, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_psel", psel, 0);
        check("rst_mid_penable", penable, 0);
        check("rst_mid_hready", hready, 1);
        check("rst_mid_hresp", hresp, 2'b00);
        check("rst_mid_hrdata", hrdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_after_psel", psel, 0);
        check("rst_after_hready", hready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
